// File: rtl/chan_scan_mux.sv
// Registered N-channel, W-bit multiplexer with manual select, auto-scan on a
// programmable dwell count, and a hold control that freezes all state.
module chan_scan_mux #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DWELL    = 50000000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [CHANNELS*WIDTH-1:0]    data_in,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         mode,
    input  logic                         hold,
    output logic [WIDTH-1:0]             data_out,
    output logic [SEL_W-1:0]             cur_chan,
    output logic                         tick
);

    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DWELL - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [SEL_W-1:0]   r_cur_chan;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_tick;

    logic [SEL_W-1:0]   w_cur_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_data_nxt;
    logic               w_tick_nxt;

    logic [SEL_W-1:0]   w_sel_clamped;
    logic [SEL_W-1:0]   w_cur_inc;
    logic               w_terminal;

    // Out-of-range manual selects collapse onto the highest real channel.
    assign w_sel_clamped = (32'(sel) >= CHANNELS) ? LAST_CHAN : sel;
    assign w_cur_inc     = (r_cur_chan == LAST_CHAN) ? '0 : r_cur_chan + SEL_W'(1);
    assign w_terminal    = (r_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: hold freezes the state, otherwise mode picks it.
    always_comb begin
        w_state_nxt = r_state;
        if (!hold) begin
            w_state_nxt = mode ? ST_SCAN : ST_MANUAL;
        end
    end

    // Next values for channel, dwell counter, tick and the output data.
    always_comb begin
        w_cur_nxt  = r_cur_chan;
        w_cnt_nxt  = r_cnt;
        w_tick_nxt = 1'b0;
        w_data_nxt = r_data;
        if (!hold) begin
            if (!mode) begin
                // Manual wins even on a terminal-count cycle.
                w_cur_nxt = w_sel_clamped;
                w_cnt_nxt = '0;
            end else if (r_state == ST_MANUAL) begin
                w_cnt_nxt = '0;
            end else if (w_terminal) begin
                w_cnt_nxt  = '0;
                w_cur_nxt  = w_cur_inc;
                w_tick_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end

            // Data follows the channel being loaded on this same edge.
            w_data_nxt = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_cur_nxt == SEL_W'(k)) begin
                    w_data_nxt = data_in[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cur_chan <= '0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_cur_chan <= w_cur_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data     <= w_data_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign data_out = r_data;
    assign cur_chan = r_cur_chan;
    assign tick     = r_tick;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: a 4-channel DWELL=3 instance, a 3-channel
// instance and a DWELL=1 instance share stimulus; each task checks its own DUT.
module tb_chan_scan_mux;

    logic        clk;
    logic        resetn;
    logic [15:0] data_in;
    logic [1:0]  sel;
    logic        mode;
    logic        hold;

    logic [3:0]  d4, d3, d1;
    logic [1:0]  c4, c3, c1;
    logic        t4, t3, t1;

    int total;
    int bad;

    localparam logic [3:0] SCAN_D [13] = '{4'h5, 4'h5, 4'h5, 4'hA, 4'hA, 4'hA,
                                           4'h2, 4'h2, 4'h2, 4'hD, 4'hD, 4'hD, 4'h5};
    localparam logic [1:0] SCAN_C [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                                           2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    localparam logic       SCAN_T [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                           1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [3:0] CH4 [4] = '{4'h5, 4'hA, 4'h2, 4'hD};
    localparam logic [3:0] CH3 [3] = '{4'h5, 4'hA, 4'h2};

    chan_scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(3), .CNT_W(2)) u_dut4 (
        .clock(clk), .resetn(resetn), .data_in(data_in), .sel(sel), .mode(mode),
        .hold(hold), .data_out(d4), .cur_chan(c4), .tick(t4)
    );

    chan_scan_mux #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(3), .CNT_W(2)) u_dut3 (
        .clock(clk), .resetn(resetn), .data_in(data_in[11:0]), .sel(sel), .mode(mode),
        .hold(hold), .data_out(d3), .cur_chan(c3), .tick(t3)
    );

    chan_scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(1), .CNT_W(1)) u_dut1 (
        .clock(clk), .resetn(resetn), .data_in(data_in), .sel(sel), .mode(mode),
        .hold(hold), .data_out(d1), .cur_chan(c1), .tick(t1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        data_in = 16'h0;
        sel     = 2'd0;
        mode    = 1'b0;
        hold    = 1'b0;
        repeat (3) step();
        total++;
        if ({d4, c4, t4} !== 7'h0) begin
            bad++;
            $display("FAIL reset_dut4: got d=%h c=%0d t=%0d expected all zero", d4, c4, t4);
        end
        total++;
        if ({d3, c3, t3} !== 7'h0) begin
            bad++;
            $display("FAIL reset_dut3: got d=%h c=%0d t=%0d expected all zero", d3, c3, t3);
        end
        total++;
        if ({d1, c1, t1} !== 7'h0) begin
            bad++;
            $display("FAIL reset_dut1: got d=%h c=%0d t=%0d expected all zero", d1, c1, t1);
        end
        resetn = 1'b1;
    endtask

    task automatic test_manual();
        logic [1:0]  sv [6] = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2};
        logic [15:0] dv [6] = '{16'hD2A5, 16'hD2A5, 16'hD2A5, 16'h1234, 16'hD2A5, 16'hD2A5};
        logic [3:0]  ed [6] = '{4'h2, 4'hA, 4'hD, 4'h1, 4'h5, 4'h2};
        mode = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel     = sv[i];
            data_in = dv[i];
            step();
            total++;
            if ({d4, c4, t4} !== {ed[i], sv[i], 1'b0}) begin
                bad++;
                $display("FAIL manual[%0d]: got d=%h c=%0d t=%0d expected d=%h c=%0d t=0",
                         i, d4, c4, t4, ed[i], sv[i]);
            end
        end
        // Asynchronous reset clears outputs between clock edges.
        resetn = 1'b0;
        #1;
        total++;
        if ({d4, c4, t4} !== 7'h0) begin
            bad++;
            $display("FAIL manual_async_reset: got d=%h c=%0d t=%0d expected all zero", d4, c4, t4);
        end
        resetn = 1'b1;
        sel    = 2'd0;
    endtask

    task automatic test_scan();
        data_in = 16'hD2A5;
        mode    = 1'b0;
        hold    = 1'b0;
        sel     = 2'd0;
        step();
        mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            total++;
            if ({d4, c4, t4} !== {SCAN_D[i], SCAN_C[i], SCAN_T[i]}) begin
                bad++;
                $display("FAIL scan[%0d]: got d=%h c=%0d t=%0d expected d=%h c=%0d t=%0d",
                         i, d4, c4, t4, SCAN_D[i], SCAN_C[i], SCAN_T[i]);
            end
        end
        mode = 1'b0;
        step();
    endtask

    task automatic test_hold();
        data_in = 16'hD2A5;
        mode    = 1'b0;
        hold    = 1'b0;
        sel     = 2'd0;
        step();
        mode = 1'b1;
        repeat (4) step();
        total++;
        if ({d4, c4, t4} !== {4'hA, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL hold_enter_ch1: got d=%h c=%0d t=%0d expected d=a c=1 t=1", d4, c4, t4);
        end
        step();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({d4, c4, t4} !== {4'hA, 2'd1, 1'b0}) begin
                bad++;
                $display("FAIL hold_frozen[%0d]: got d=%h c=%0d t=%0d expected d=a c=1 t=0",
                         i, d4, c4, t4);
            end
        end
        hold = 1'b0;
        step();
        total++;
        if ({d4, c4, t4} !== {4'hA, 2'd1, 1'b0}) begin
            bad++;
            $display("FAIL hold_release_remaining: got d=%h c=%0d t=%0d expected d=a c=1 t=0", d4, c4, t4);
        end
        step();
        total++;
        if ({d4, c4, t4} !== {4'h2, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL hold_release_advance: got d=%h c=%0d t=%0d expected d=2 c=2 t=1", d4, c4, t4);
        end
        // A mode change made while held takes effect only after release.
        hold = 1'b1;
        mode = 1'b0;
        sel  = 2'd3;
        step();
        total++;
        if ({d4, c4, t4} !== {4'h2, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL hold_mode_deferred: got d=%h c=%0d t=%0d expected d=2 c=2 t=0", d4, c4, t4);
        end
        hold = 1'b0;
        step();
        total++;
        if ({d4, c4, t4} !== {4'hD, 2'd3, 1'b0}) begin
            bad++;
            $display("FAIL hold_mode_applied: got d=%h c=%0d t=%0d expected d=d c=3 t=0", d4, c4, t4);
        end
        sel = 2'd0;
        step();
    endtask

    task automatic test_clamp();
        logic [1:0] ec;
        logic       et;
        data_in = 16'hD2A5;
        mode    = 1'b0;
        hold    = 1'b0;
        sel     = 2'd3;
        step();
        total++;
        if ({d3, c3, t3} !== {4'h2, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL clamp_sel3: got d=%h c=%0d t=%0d expected d=2 c=2 t=0", d3, c3, t3);
        end
        sel = 2'd0;
        step();
        mode = 1'b1;
        for (int j = 0; j < 13; j++) begin
            step();
            ec = 2'((j / 3) % 3);
            et = (j > 0) && (j % 3 == 0);
            total++;
            if ({d3, c3, t3} !== {CH3[ec], ec, et}) begin
                bad++;
                $display("FAIL clamp_scan[%0d]: got d=%h c=%0d t=%0d expected d=%h c=%0d t=%0d",
                         j, d3, c3, t3, CH3[ec], ec, et);
            end
        end
        mode = 1'b0;
        step();
    endtask

    task automatic test_terminal_drop();
        data_in = 16'hD2A5;
        mode    = 1'b0;
        hold    = 1'b0;
        sel     = 2'd0;
        step();
        mode = 1'b1;
        repeat (3) step();
        mode = 1'b0;
        sel  = 2'd3;
        step();
        total++;
        if ({d4, c4, t4} !== {4'hD, 2'd3, 1'b0}) begin
            bad++;
            $display("FAIL terminal_drop: got d=%h c=%0d t=%0d expected d=d c=3 t=0", d4, c4, t4);
        end
        // Re-entering scan shows the counter restarted from zero.
        mode = 1'b1;
        repeat (3) step();
        total++;
        if ({d4, c4, t4} !== {4'hD, 2'd3, 1'b0}) begin
            bad++;
            $display("FAIL terminal_cnt_cleared: got d=%h c=%0d t=%0d expected d=d c=3 t=0", d4, c4, t4);
        end
        step();
        total++;
        if ({d4, c4, t4} !== {4'h5, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL terminal_wrap: got d=%h c=%0d t=%0d expected d=5 c=0 t=1", d4, c4, t4);
        end
        mode = 1'b0;
        sel  = 2'd0;
        step();
    endtask

    task automatic test_dwell1();
        logic [1:0] ec;
        data_in = 16'hD2A5;
        mode    = 1'b0;
        hold    = 1'b0;
        sel     = 2'd0;
        step();
        mode = 1'b1;
        step();
        total++;
        if ({d1, c1, t1} !== {4'h5, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL dwell1_entry: got d=%h c=%0d t=%0d expected d=5 c=0 t=0", d1, c1, t1);
        end
        for (int j = 1; j <= 6; j++) begin
            step();
            ec = 2'(j % 4);
            total++;
            if ({d1, c1, t1} !== {CH4[ec], ec, 1'b1}) begin
                bad++;
                $display("FAIL dwell1_scan[%0d]: got d=%h c=%0d t=%0d expected d=%h c=%0d t=1",
                         j, d1, c1, t1, CH4[ec], ec);
            end
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({d1, c1, t1} !== 7'h0) begin
            bad++;
            $display("FAIL dwell1_reset: got d=%h c=%0d t=%0d expected all zero", d1, c1, t1);
        end
        #1;
        resetn = 1'b1;
        step();
        total++;
        if ({d1, c1, t1} !== {4'h5, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL dwell1_after_reset: got d=%h c=%0d t=%0d expected d=5 c=0 t=0", d1, c1, t1);
        end
        step();
        total++;
        if ({d1, c1, t1} !== {4'hA, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL dwell1_resume: got d=%h c=%0d t=%0d expected d=a c=1 t=1", d1, c1, t1);
        end
        mode = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_manual();
        test_scan();
        test_hold();
        test_clamp();
        test_terminal_drop();
        test_dwell1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chan_scan_mux.md
Name: chan_scan_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Generalises the single-bit 2:1 select to CHANNELS inputs of WIDTH bits each.
- Adds an auto-scan mode that steps through channels on a programmable dwell count, plus a hold (freeze) control.
- Sits between switch/data sources and LED or HEX display logic on the board top level.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels (≥2).
- SEL_W, 2, select width; must satisfy 2**SEL_W ≥ CHANNELS.
- DWELL, 50000000, clock cycles spent on each channel in scan mode (≥1).
- CNT_W, 26, dwell counter width; must satisfy 2**CNT_W ≥ DWELL.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- data_in, input, CHANNELS*WIDTH, packed channels; channel k = data_in[k*WIDTH +: WIDTH].
- sel, input, SEL_W, manual channel select.
- mode, input, 1, 0 = manual, 1 = auto-scan.
- hold, input, 1, 1 = freeze all state.
- data_out, output, WIDTH, registered selected channel.
- cur_chan, output, SEL_W, channel currently driving data_out.
- tick, output, 1, one-cycle pulse on each auto-scan channel advance.

Behaviour:
- Reset (resetn=0, asynchronous, takes effect immediately):
  - state=MANUAL, cur_chan=0, dwell counter=0, data_out=0, tick=0.
  - Reset asserted mid-scan aborts the scan. No state survives.
- Output path:
  - Every non-held cycle: data_out <= channel[cur_chan_next], where cur_chan_next is the value cur_chan takes on the same edge.
  - Result: data_out and cur_chan always agree.
  - Latency from sel or data_in change to data_out is exactly 1 cycle.
- State machine, two states:
  - MANUAL: cur_chan <= sel each cycle. If sel ≥ CHANNELS, clamp to CHANNELS-1. Dwell counter held at 0. tick=0.
  - SCAN, when counter < DWELL-1: counter increments.
  - SCAN, when counter == DWELL-1: counter <= 0, cur_chan <= cur_chan+1, wrapping CHANNELS-1 -> 0, and tick=1 for that one cycle (registered, coincident with the new cur_chan).
- Transitions:
  - MANUAL -> SCAN when mode=1. Counter starts at 0 and scan begins from the current cur_chan; the first advance occurs DWELL cycles after entry.
  - SCAN -> MANUAL when mode=0. Next edge loads the clamped sel, clears the counter and forces tick=0.
- Hold:
  - hold=1 has priority over mode and scan.
  - cur_chan, counter, state and data_out keep their values; tick=0.
  - On release, operation resumes from the frozen counter value; no cycles are skipped or repeated.
  - A mode change while held is applied on the first cycle after release.
- DWELL=1: advance every cycle; tick is constantly 1 while scanning.
- Non-power-of-2 CHANNELS: scan never visits channel indices ≥ CHANNELS.
- Simultaneous mode=0 on the terminal-count cycle: MANUAL wins. No advance, no tick.
- No combinational path from any input to any output.

Test Plan (WIDTH=4, CHANNELS=4, DWELL=3 unless stated):
- Reset, then data_in=16'hD2A5, mode=0, sel=2 -> data_out=4'h2 and cur_chan=2 one cycle after sel applied; with resetn=0, outputs are 0 immediately, without waiting for a clock edge.
- data_in=16'hD2A5, mode=1 from cur_chan=0 -> data_out sequence 5,5,5,A,A,A,2,2,2,D,D,D,5; tick high on the first cycle of each new value; cur_chan wraps 3 -> 0.
- Scanning, hold=1 for 5 cycles midway through channel 1 dwell -> cur_chan stays 1, data_out stays A, tick=0; after release, channel 1 completes exactly its remaining dwell cycles.
- CHANNELS=3, SEL_W=2, sel=3 in manual -> cur_chan=2 (clamped); scan mode -> sequence 0,1,2,0, never 3.
- mode dropped to 0 on the cycle the counter equals DWELL-1, with sel=3 -> no tick; cur_chan=3 next cycle; counter=0.
- DWELL=1, mode=1 -> cur_chan increments every cycle and tick stays 1 continuously; resetn pulsed low mid-scan -> cur_chan=0, tick=0, state MANUAL after release.
